serial_sub_3b: RTL

SERIAL_SUB_3B -- requirements
Module: serial_sub_3b

---
 rtl/serial_sub_3b_if.sv | 26 ++
 rtl/serial_sub_3b.sv | 127 ++++++++++++
 2 files changed

// File: rtl/serial_sub_3b_if.sv
// serial_sub_3b_if: request/result bundle for the 3-bit serial subtractor.
//   start, A, B, Bin : request and operands (producer -> subtractor)
//   ack              : consumer acknowledge of the result
//   busy, done, D    : status and registered result (subtractor -> consumer)
interface serial_sub_3b_if;
  logic       start;
  logic [2:0] A;
  logic [2:0] B;
  logic       Bin;
  logic       ack;
  logic       busy;
  logic       done;
  logic [3:0] D;

  // Producer / consumer side
  modport master (
    output start, A, B, Bin, ack,
    input  busy, done, D
  );

  // Subtractor side
  modport slave (
    input  start, A, B, Bin, ack,
    output busy, done, D
  );
endinterface

// File: rtl/serial_sub_3b.sv
// serial_sub_3b: bit-serial 3-bit subtractor, LSB first, one bit per cycle.
// Computes D = {borrow_out, (A - B - Bin) mod 8} with fixed 3-cycle RUN phase,
// then holds the result in DONE until acknowledged.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of serial_sub_3b_if (start/A/B/Bin/ack in, busy/done/D out)
module serial_sub_3b (
  input  logic                  clk,
  input  logic                  rst_n,
  serial_sub_3b_if.slave        bus
);

  localparam int unsigned OP_W  = 3;
  localparam int unsigned IDX_W = 2;
  localparam int unsigned D_W   = OP_W + 1;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  logic [1:0]       state_q, state_d;
  logic [OP_W-1:0]  a_q, a_d;
  logic [OP_W-1:0]  b_q, b_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             br_q, br_d;
  logic [OP_W-1:0]  diff_q, diff_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [D_W-1:0]   d_q, d_d;

  // Current bit slice: operands shift right so bit 0 is always the active bit
  logic ai_c, bi_c, di_c, br_nxt_c;

  always_comb begin
    ai_c     = a_q[0];
    bi_c     = b_q[0];
    di_c     = ai_c ^ bi_c ^ br_q;
    br_nxt_c = (~ai_c & bi_c) | (~(ai_c ^ bi_c) & br_q);
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    br_d    = br_q;
    diff_d  = diff_q;
    busy_d  = busy_q;
    done_d  = done_q;
    d_d     = d_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          a_d     = bus.A;
          b_d     = bus.B;
          br_d    = bus.Bin;
          idx_d   = '0;
          diff_d  = '0;
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        br_d   = br_nxt_c;
        // Difference bits enter at the MSB and shift down; after 3 bits
        // the register holds {d2, d1, d0}.
        diff_d = {di_c, diff_q[OP_W-1:1]};
        idx_d  = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(OP_W - 1)) begin
          d_d     = {br_nxt_c, di_c, diff_q[OP_W-1:1]};
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        // start is ignored here, even when it arrives together with ack
        if (bus.ack) begin
          done_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        busy_d  = 1'b0;
        done_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      br_q    <= 1'b0;
      diff_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      d_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      br_q    <= br_d;
      diff_q  <= diff_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      d_q     <= d_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.D    = d_q;

endmodule
